// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - IF-stage fetch engine: PC ownership, single-outstanding imem read, IF/ID hold
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ID_data_PCNext,
  output logic [31:0] o_ID_data_instruction,
  output logic        o_ID_bubble
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pcnext;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_discard_nxt;
  logic        w_valid_nxt;
  logic        w_capture;
  logic        w_accept;
  logic [31:0] w_pc_plus;

  // Request is gated by reset so nothing reaches memory while nrst is low.
  assign o_imem_req  = (r_state == ST_REQ) && nrst;
  assign o_imem_addr = r_pc;
  assign w_accept    = o_imem_req && i_imem_ready;
  assign w_pc_plus   = r_pc + PC_STEP;

  assign o_ID_data_PCNext      = r_pcnext;
  assign o_ID_data_instruction = r_instr;
  assign o_ID_bubble           = ~r_valid;

  // Next-state logic: redirect beats stall and is honoured in every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_valid_nxt   = r_valid;
    w_capture     = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
        end
        if (i_redirect) begin
          w_pc_nxt = i_redirect_target;
          // The old request is already in flight; its data must be dropped.
          if (w_accept) begin
            w_discard_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (i_redirect) begin
          w_pc_nxt = i_redirect_target;
        end
        if (i_imem_rvalid) begin
          if (r_discard || i_redirect) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_REQ;
          end else begin
            w_capture   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_VALID;
          end
        end else if (i_redirect) begin
          w_discard_nxt = 1'b1;
        end
      end
      ST_VALID: begin
        if (i_redirect) begin
          w_pc_nxt    = i_redirect_target;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_REQ;
        end else if (!stall) begin
          w_pc_nxt    = w_pc_plus;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt   = ST_REQ;
        w_discard_nxt = 1'b0;
        w_valid_nxt   = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // IF/ID payload registers only move on an accepted read response.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_instr  <= 32'h0000_0000;
      r_pcnext <= 32'h0000_0000;
    end else if (w_capture) begin
      r_instr  <= i_imem_rdata;
      r_pcnext <= w_pc_plus;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed vector bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        i_redirect;
  logic [31:0] i_redirect_target;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  logic        req_a, req_w;
  logic [31:0] addr_a, addr_w;
  logic [31:0] pcn_a, pcn_w;
  logic [31:0] ins_a, ins_w;
  logic        bub_a, bub_w;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk(clk), .nrst(nrst), .stall(stall),
    .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
    .o_imem_req(req_a), .o_imem_addr(addr_a),
    .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_ID_data_PCNext(pcn_a), .o_ID_data_instruction(ins_a), .o_ID_bubble(bub_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
    .clk(clk), .nrst(nrst), .stall(stall),
    .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
    .o_imem_req(req_w), .o_imem_addr(addr_w),
    .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_ID_data_PCNext(pcn_w), .o_ID_data_instruction(ins_w), .o_ID_bubble(bub_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_bub;
    logic [31:0] e_ins;
    logic [31:0] e_pcn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t,
                       input logic rd, input logic rv, input logic [31:0] d);
    stall = s; i_redirect = r; i_redirect_target = t;
    i_imem_ready = rd; i_imem_rvalid = rv; i_imem_rdata = d;
  endtask

  initial begin
    // stall redir target ready rvalid rdata | req addr bubble instr pcnext
    vecs.push_back('{0,0,32'h0,  1,0,32'h0,         1,32'h0,  1,32'h0,         32'h0});
    vecs.push_back('{0,0,32'h0,  0,1,32'h2008_0005, 0,32'h0,  1,32'h0,         32'h0});
    vecs.push_back('{1,0,32'h0,  0,0,32'h0,         0,32'h0,  0,32'h2008_0005, 32'h4});
    vecs.push_back('{1,0,32'h0,  0,0,32'h0,         0,32'h0,  0,32'h2008_0005, 32'h4});
    vecs.push_back('{1,0,32'h0,  0,0,32'h0,         0,32'h0,  0,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         0,32'h0,  0,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  1,0,32'h0,         1,32'h4,  1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,1,32'h100,0,1,32'hDEAD_BEEF, 0,32'h0,  1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         1,32'h100,1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         1,32'h100,1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,1,32'h40, 0,0,32'h0,         1,32'h100,1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         1,32'h40, 1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  1,0,32'h0,         1,32'h40, 1,32'h2008_0005, 32'h4});
    vecs.push_back('{0,0,32'h0,  0,1,32'h1234_5678, 0,32'h0,  1,32'h2008_0005, 32'h4});
    vecs.push_back('{1,1,32'h200,0,0,32'h0,         0,32'h0,  0,32'h1234_5678, 32'h44});
    vecs.push_back('{0,1,32'h300,1,0,32'h0,         1,32'h200,1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  0,1,32'hAAAA_AAAA, 0,32'h0,  1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  0,1,32'hBBBB_BBBB, 1,32'h300,1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  1,0,32'h0,         1,32'h300,1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         0,32'h0,  1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  0,1,32'hCAFE_F00D, 0,32'h0,  1,32'h1234_5678, 32'h44});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         0,32'h0,  0,32'hCAFE_F00D, 32'h304});
    vecs.push_back('{0,0,32'h0,  0,0,32'h0,         1,32'h304,1,32'hCAFE_F00D, 32'h304});

    nrst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk("reset_req",    {31'd0, req_a}, 32'd0);
    chk("reset_bubble", {31'd0, bub_a}, 32'd1);
    chk("reset_instr",  ins_a, 32'h0);
    chk("reset_pcnext", pcn_a, 32'h0);
    nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].redir, vecs[i].target,
            vecs[i].ready, vecs[i].rvalid, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, req_a}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), addr_a, vecs[i].e_addr);
      chk($sformatf("v%0d_bubble", i), {31'd0, bub_a}, {31'd0, vecs[i].e_bub});
      chk($sformatf("v%0d_instr", i), ins_a, vecs[i].e_ins);
      chk($sformatf("v%0d_pcnext", i), pcn_a, vecs[i].e_pcn);
    end

    // Wrap-around and mid-flight reset on the RESET_PC=0xFFFF_FFFC instance.
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    nrst = 1'b0;
    #1;
    chk("w_reset_req",    {31'd0, req_w}, 32'd0);
    chk("w_reset_bubble", {31'd0, bub_w}, 32'd1);
    nrst = 1'b1;
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("w_req0",  {31'd0, req_w}, 32'd1);
    chk("w_addr0", addr_w, 32'hFFFF_FFFC);
    @(negedge clk); drive(0, 0, 32'h0, 0, 1, 32'h1111_1111); #1;
    chk("w_wait_req", {31'd0, req_w}, 32'd0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0); #1;
    chk("w_instr",  ins_w, 32'h1111_1111);
    chk("w_pcnext", pcn_w, 32'h0000_0000);
    chk("w_bubble", {31'd0, bub_w}, 32'd0);
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("w_req1",  {31'd0, req_w}, 32'd1);
    chk("w_addr1", addr_w, 32'h0000_0000);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0); #1;
    chk("w_wait2_req", {31'd0, req_w}, 32'd0);
    nrst = 1'b0;
    #1;
    chk("w_abort_req",    {31'd0, req_w}, 32'd0);
    chk("w_abort_bubble", {31'd0, bub_w}, 32'd1);
    chk("w_abort_instr",  ins_w, 32'h0);
    chk("w_abort_pcnext", pcn_w, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    drive(0, 0, 32'h0, 0, 1, 32'hDEAD_0001);
    #1;
    chk("w_stray_req",  {31'd0, req_w}, 32'd1);
    chk("w_stray_addr", addr_w, 32'hFFFF_FFFC);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0); #1;
    chk("w_after_req",    {31'd0, req_w}, 32'd1);
    chk("w_after_addr",   addr_w, 32'hFFFF_FFFC);
    chk("w_after_bubble", {31'd0, bub_w}, 32'd1);
    chk("w_after_instr",  ins_w, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
